hazard_sb: RTL and testbench

Parametrised scoreboard hazard unit for the bexkat1 pipeline. It sits beside the ID stage and does three things: tracks pending register writes with per-register countdown counters, generates operand forwarding selects for a configurable number of source operands and forwarding stages, and stalls issue on RAW or WAW conflicts with multi-cycle producers (loads, multiplier, divider). It replaces fixed two-stage, single-cycle-latency hazard detection with latency-aware, depth-generic detection, and adds a stall statistics counter.

---
 rtl/hazard_sb.sv | 102 ++++++++++
 tb/tb_hazard_sb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb: latency-aware scoreboard hazard unit beside the ID stage.
// Tracks pending writes, selects forwarding sources, stalls on RAW/WAW.
module hazard_sb #(
  parameter int NREGS  = 16,
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int MAXLAT = 7,
  localparam int RW = $clog2(NREGS),
  localparam int FW = $clog2(NFWD + 1),
  localparam int CW = $clog2(MAXLAT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [NSRC-1:0]      id_src_en_i,
  input  logic [NSRC*RW-1:0]   id_src_i,
  input  logic                 id_dst_en_i,
  input  logic [RW-1:0]        id_dst_i,
  input  logic [CW-1:0]        id_lat_i,
  input  logic                 flush_i,
  input  logic [NFWD-1:0]      st_wr_i,
  input  logic [NFWD*RW-1:0]   st_dst_i,
  output logic                 stall_o,
  output logic                 issue_o,
  output logic [NSRC*FW-1:0]   fwd_o,
  output logic [NREGS-1:0]     busy_o,
  output logic [15:0]          stall_cnt_o
);

  logic [CW-1:0] cnt_q [NREGS];
  logic [CW-1:0] cnt_d [NREGS];
  logic [15:0]   stall_cnt_q;
  logic [15:0]   stall_cnt_d;
  logic          raw;
  logic          waw;
  logic          live;

  // RAW on any enabled source still counting; WAW if older result lands later
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_src_en_i[k] && cnt_q[id_src_i[k*RW +: RW]] != '0)
        raw = 1'b1;
    end
    waw = id_dst_en_i && (cnt_q[id_dst_i] > id_lat_i);
  end

  assign live    = id_valid_i && !flush_i;
  assign stall_o = live && (raw || waw);
  assign issue_o = live && !(raw || waw);

  // youngest matching stage wins: scan oldest to youngest, last hit sticks
  always_comb begin
    fwd_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (id_valid_i && id_src_en_i[k] && st_wr_i[i] &&
            st_dst_i[i*RW +: RW] == id_src_i[k*RW +: RW])
          fwd_o[k*FW +: FW] = FW'(i + 1);
      end
    end
  end

  // per-register countdown: a new issue reloads, otherwise count to zero
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_o && id_dst_en_i && id_dst_i == RW'(r))
        cnt_d[r] = id_lat_i;
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CW'(1);
    end
  end

  // saturating stall cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // state registers, synchronous active-low reset drops all pending writes
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // busy view of the counters
  always_comb begin
    for (int r = 0; r < NREGS; r++)
      busy_o[r] = (cnt_q[r] != '0);
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: vector table, directed corner sequences and random
// stimulus against a ready-time reference model.
module tb_hazard_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [1:0]  id_src_en_i;
  logic [7:0]  id_src_i;
  logic        id_dst_en_i;
  logic [3:0]  id_dst_i;
  logic [2:0]  id_lat_i;
  logic        flush_i;
  logic [1:0]  st_wr_i;
  logic [7:0]  st_dst_i;
  logic        stall_o;
  logic        issue_o;
  logic [3:0]  fwd_o;
  logic [15:0] busy_o;
  logic [15:0] stall_cnt_o;

  hazard_sb dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_src_en_i(id_src_en_i), .id_src_i(id_src_i),
    .id_dst_en_i(id_dst_en_i), .id_dst_i(id_dst_i),
    .id_lat_i(id_lat_i), .flush_i(flush_i), .st_wr_i(st_wr_i),
    .st_dst_i(st_dst_i), .stall_o(stall_o), .issue_o(issue_o),
    .fwd_o(fwd_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: cycle at which each register's result is usable
  int unsigned cyc = 0;
  int unsigned ready [16];
  int unsigned m_scnt = 0;

  function automatic int unsigned rem(input int r);
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic bit m_stall();
    bit hz = 0;
    for (int k = 0; k < 2; k++)
      if (id_src_en_i[k] && rem(int'(id_src_i[k*4 +: 4])) > 0) hz = 1;
    if (id_dst_en_i && rem(int'(id_dst_i)) > int'(id_lat_i)) hz = 1;
    return id_valid_i && !flush_i && hz;
  endfunction

  function automatic bit m_issue();
    return id_valid_i && !flush_i && !m_stall();
  endfunction

  function automatic logic [3:0] m_fwd();
    logic [3:0] f = '0;
    for (int k = 0; k < 2; k++) begin
      int sel = 0;
      if (id_valid_i && id_src_en_i[k])
        for (int i = 0; i < 2; i++)
          if (sel == 0 && st_wr_i[i] && st_dst_i[i*4 +: 4] == id_src_i[k*4 +: 4])
            sel = i + 1;
      f[k*2 +: 2] = 2'(sel);
    end
    return f;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = rem(r) > 0;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".stall"}, 32'(stall_o), 32'(m_stall()));
    chk({tag, ".issue"}, 32'(issue_o), 32'(m_issue()));
    chk({tag, ".fwd"}, 32'(fwd_o), 32'(m_fwd()));
    chk({tag, ".busy"}, 32'(busy_o), 32'(m_busy()));
    chk({tag, ".scnt"}, 32'(stall_cnt_o), m_scnt);
  endtask

  // advance one clock edge, updating the model with the pre-edge inputs
  task automatic tick();
    bit iss = m_issue();
    bit stl = m_stall();
    @(posedge clk_i);
    cyc++;
    if (!rst_i) begin
      for (int r = 0; r < 16; r++) ready[r] = 0;
      m_scnt = 0;
    end else begin
      if (iss && id_dst_en_i) ready[id_dst_i] = cyc + id_lat_i;
      if (stl && m_scnt < 65535) m_scnt++;
    end
    #1;
  endtask

  task automatic set(input bit v, input logic [1:0] sen,
                     input logic [3:0] s0, input logic [3:0] s1,
                     input bit den, input logic [3:0] d,
                     input logic [2:0] lat, input bit fl,
                     input logic [1:0] sw, input logic [3:0] sd0,
                     input logic [3:0] sd1);
    id_valid_i = v; id_src_en_i = sen; id_src_i = {s1, s0};
    id_dst_en_i = den; id_dst_i = d; id_lat_i = lat; flush_i = fl;
    st_wr_i = sw; st_dst_i = {sd1, sd0};
    #1;
  endtask

  task automatic rnd_inputs();
    id_valid_i  = ($urandom_range(0, 9) < 8);
    id_src_en_i = 2'($urandom);
    id_src_i    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
    id_dst_en_i = 1'($urandom);
    id_dst_i    = 4'($urandom_range(0, 7));
    id_lat_i    = 3'($urandom_range(0, 7));
    flush_i     = ($urandom_range(0, 9) == 0);
    st_wr_i     = 2'($urandom);
    st_dst_i    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
  endtask

  typedef struct {
    bit v; logic [1:0] sen; logic [3:0] s0, s1;
    bit fl; logic [1:0] sw; logic [3:0] sd0, sd1;
    bit e_stall, e_issue; logic [1:0] e_f0, e_f1;
  } vec_t;

  vec_t vt [6];

  initial begin
    for (int r = 0; r < 16; r++) ready[r] = 0;

    // forwarding / issue vectors from a clean scoreboard (no dst writes)
    vt[0] = '{1, 2'b11, 5, 6, 0, 2'b11, 5, 5, 0, 1, 2'd1, 2'd0};
    vt[1] = '{1, 2'b11, 3, 3, 0, 2'b10, 3, 3, 0, 1, 2'd2, 2'd2};
    vt[2] = '{0, 2'b11, 3, 3, 0, 2'b11, 3, 3, 0, 0, 2'd0, 2'd0};
    vt[3] = '{1, 2'b01, 3, 3, 0, 2'b11, 4, 3, 0, 1, 2'd2, 2'd0};
    vt[4] = '{1, 2'b11, 9, 4, 1, 2'b01, 4, 4, 0, 0, 2'd0, 2'd1};
    vt[5] = '{1, 2'b11, 1, 2, 0, 2'b00, 1, 2, 0, 1, 2'd0, 2'd0};

    // reset held two edges with random inputs
    rst_i = 1'b0;
    rnd_inputs();
    tick();
    rnd_inputs();
    tick();
    rst_i = 1'b1;
    set(1, 2'b11, 4'($urandom), 4'($urandom), 0, 0, 0, 0, 2'b00, 0, 0);
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.scnt", 32'(stall_cnt_o), 0);
    chk("rst.stall", 32'(stall_o), 0);

    // load-use
    set(1, 2'b00, 0, 0, 1, 3, 1, 0, 2'b00, 0, 0);
    chk("lu.issue_ld", 32'(issue_o), 1);
    tick();
    set(1, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("lu.stall", 32'(stall_o), 1);
    chk("lu.noissue", 32'(issue_o), 0);
    chk_model("lu1");
    tick();
    set(1, 2'b01, 3, 0, 0, 0, 0, 0, 2'b10, 0, 3);
    chk("lu.issue", 32'(issue_o), 1);
    chk("lu.fwd", 32'(fwd_o[1:0]), 2);
    chk("lu.scnt", 32'(stall_cnt_o), 1);
    chk_model("lu2");

    // table vectors
    for (int i = 0; i < 6; i++) begin
      set(vt[i].v, vt[i].sen, vt[i].s0, vt[i].s1, 0, 0, 0, vt[i].fl,
          vt[i].sw, vt[i].sd0, vt[i].sd1);
      chk($sformatf("vec%0d.stall", i), 32'(stall_o), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d.issue", i), 32'(issue_o), 32'(vt[i].e_issue));
      chk($sformatf("vec%0d.f0", i), 32'(fwd_o[1:0]), 32'(vt[i].e_f0));
      chk($sformatf("vec%0d.f1", i), 32'(fwd_o[3:2]), 32'(vt[i].e_f1));
      tick();
    end

    // multi-cycle producer lat=4
    set(1, 2'b00, 0, 0, 1, 7, 4, 0, 2'b00, 0, 0);
    chk("mc.issue_p", 32'(issue_o), 1);
    tick();
    set(1, 2'b01, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mc.stall%0d", i), 32'(stall_o), 1);
      chk($sformatf("mc.busy%0d", i), 32'(busy_o[7]), 1);
      chk_model("mc");
      tick();
    end
    chk("mc.busy_clr", 32'(busy_o[7]), 0);
    chk("mc.issue", 32'(issue_o), 1);
    chk("mc.scnt", 32'(stall_cnt_o), 5);

    // WAW: r2 counter 3, then dst r2 lat 0
    set(1, 2'b00, 0, 0, 1, 2, 3, 0, 2'b00, 0, 0);
    tick();
    set(1, 2'b00, 0, 0, 1, 2, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("waw.stall%0d", i), 32'(stall_o), 1);
      tick();
    end
    chk("waw.issue", 32'(issue_o), 1);
    tick();
    set(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("waw.busy2", 32'(busy_o[2]), 0);
    chk("waw.scnt", 32'(stall_cnt_o), 8);

    // same-edge reload beats decrement: counter[4] 1 -> 2
    set(1, 2'b00, 0, 0, 1, 4, 1, 0, 2'b00, 0, 0);
    tick();
    set(1, 2'b00, 0, 0, 1, 4, 2, 0, 2'b00, 0, 0);
    chk("se.issue", 32'(issue_o), 1);
    tick();
    set(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    chk("se.busy_after1", 32'(busy_o[4]), 1);
    tick();
    chk("se.busy_after2", 32'(busy_o[4]), 0);

    // flush during a stall, then reset with counters pending
    set(1, 2'b00, 0, 0, 1, 3, 3, 0, 2'b00, 0, 0);
    tick();
    set(1, 2'b01, 3, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    chk("fl.stall", 32'(stall_o), 0);
    chk("fl.issue", 32'(issue_o), 0);
    tick();
    chk("fl.busy", 32'(busy_o[3]), 1);
    chk_model("fl");
    tick();
    chk_model("fl2");
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("mrst.busy", 32'(busy_o), 0);
    chk("mrst.scnt", 32'(stall_cnt_o), 0);

    // random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      rnd_inputs();
      rst_i = ($urandom_range(0, 199) != 0);
      #1;
      if (rst_i) chk_model("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
